// File: rtl/soda_machine_types.sv
// Shared types and coin constants for the soda machine change path.
package soda_machine_types;

   typedef enum logic [1:0] {InsNone, InsCoin1, InsCoin2, InsCoin4} insert_type;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StWait1,
      StWait2,
      StGap,
      StFault
   } disp_state_t;

   localparam logic [4:0] C1       = 5'd1;
   localparam logic [4:0] C2       = 5'd2;
   localparam logic [4:0] OWED_MAX = 5'd31;

endpackage

// File: rtl/hopper_watchdog.sv
// Per-hopper ack watchdog: flags a hopper as failed when its request goes
// unanswered for TIMEOUT consecutive cycles.
module hopper_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic ack,
   output logic expired,
   output logic failed
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             failed_q;

   // Fires in the last waiting cycle so the request is high for exactly TIMEOUT cycles.
   assign expired = active && !ack && (cnt_q == CNT_W'(TIMEOUT - 1));
   assign failed  = failed_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         failed_q <= 1'b0;
      end else begin
         if (!active || ack || expired) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (expired) begin
            failed_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accumulates owed units and pays them out via a 2-unit and
// a 1-unit coin hopper, preferring 2-unit coins.
module change_dispenser
   import soda_machine_types::*;
#(
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       change1,
   input  logic       change2,
   input  logic       change22,
   input  logic       hop1_empty,
   input  logic       hop2_empty,
   input  logic       hop1_ack,
   input  logic       hop2_ack,
   output logic       hop1_req,
   output logic       hop2_req,
   output logic [4:0] owed,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic       ovf
);

   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   disp_state_t      state_q, state_d;
   logic [4:0]       owed_q, owed_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic             exp1, exp2, failed1, failed2;
   logic             use1, use2, can_pay;
   logic [2:0]       add;
   logic [4:0]       paid;
   logic [6:0]       sum;

   hopper_watchdog #(.TIMEOUT(TIMEOUT)) u_wd1 (
      .clk     (clk),
      .reset   (reset),
      .active  (state_q == StWait1),
      .ack     (hop1_ack),
      .expired (exp1),
      .failed  (failed1)
   );

   hopper_watchdog #(.TIMEOUT(TIMEOUT)) u_wd2 (
      .clk     (clk),
      .reset   (reset),
      .active  (state_q == StWait2),
      .ack     (hop2_ack),
      .expired (exp2),
      .failed  (failed2)
   );

   assign use1    = !hop1_empty && !failed1;
   assign use2    = !hop2_empty && !failed2;
   assign can_pay = ((owed_q >= C2) && use2) || ((owed_q >= C1) && use1);
   // Bit positions give weights 1, 2 and 4 directly.
   assign add     = {change22, change2, change1};

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      paid    = '0;
      unique case (state_q)
         StIdle: begin
            if (owed_q != '0) state_d = StSelect;
         end
         StSelect: begin
            if ((owed_q >= C2) && use2)      state_d = StWait2;
            else if ((owed_q >= C1) && use1) state_d = StWait1;
            else if (owed_q == '0)           state_d = StIdle;
            else                             state_d = StFault;
         end
         StWait1: begin
            if (hop1_ack) begin
               paid    = C1;
               gap_d   = '0;
               state_d = StGap;
            end else if (exp1) begin
               state_d = StSelect;
            end
         end
         StWait2: begin
            if (hop2_ack) begin
               paid    = C2;
               gap_d   = '0;
               state_d = StGap;
            end else if (exp2) begin
               state_d = StSelect;
            end
         end
         StGap: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               if (owed_q == '0) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = StSelect;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         StFault: begin
            if (can_pay || (owed_q == '0)) state_d = StSelect;
         end
         default: state_d = StIdle;
      endcase

      sum = {2'b00, owed_q} + {4'b0000, add} - {2'b00, paid};
      if (sum > 7'd31) begin
         owed_d = OWED_MAX;
         ovf_d  = 1'b1;
      end else begin
         owed_d = sum[4:0];
         ovf_d  = ovf_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         owed_q  <= '0;
         gap_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owed_q  <= owed_d;
         gap_q   <= gap_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign hop1_req = (state_q == StWait1);
   assign hop2_req = (state_q == StWait2);
   assign owed     = owed_q;
   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign fault    = (state_q == StFault);
   assign ovf      = ovf_q;

endmodule
